seq_div8_core: RTL and testbench

//   Sequential radix-2 restoring divider; the inverse companion of the Booth multiplier core.

---
 rtl/seq_div8_core_pkg.sv | 45 ++++
 rtl/seq_div8_core_step.sv | 33 +++
 rtl/seq_div8_core.sv | 176 +++++++++++++++++
 tb/tb_seq_div8_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div8_core_pkg.sv
// Shared definitions for the sequential divider: state encoding, the
// per-operation context record and the sign helper functions that are also
// used by the multiplier core.
package seq_div8_core_pkg;

  // Default operand width of the divider.
  localparam int unsigned DEF_WIDTH = 8;

  // Working width of the helper functions; callers extend into it and
  // truncate back to their own width, so the helpers serve any WIDTH <= 64.
  localparam int unsigned FW = 64;

  // Controller state encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Sign/mode information captured at accept and needed at the fix-up step.
  typedef struct packed {
    logic sign_n;   // dividend was negative (and treated as signed)
    logic sign_d;   // divisor was negative (and treated as signed)
    logic dz;       // divisor was zero
    logic uns;      // both operands unsigned: result domain is unsigned
  } op_ctx_t;

  // Two's complement negation; the low bits of the result are the correct
  // negation at any narrower width.
  function automatic logic [FW-1:0] f_neg(input logic [FW-1:0] value);
    return ~value + 64'd1;
  endfunction

  // Magnitude of a value. The caller sign-extends its operand into FW bits,
  // so bit FW-1 carries the operand's sign bit.
  function automatic logic [FW-1:0] f_abs(input logic [FW-1:0] value,
                                          input logic            is_signed);
    logic [FW-1:0] result;
    if (is_signed && value[FW-1]) begin
      result = f_neg(value);
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_div8_core_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor magnitude if it fits.
module div_restore_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   p_i,      // current partial remainder
  input  logic             q_msb_i,  // next dividend bit (quotient register msb)
  input  logic [WIDTH-1:0] dvs_i,    // divisor magnitude
  output logic [WIDTH:0]   p_o,      // next partial remainder
  output logic             q_bit_o   // quotient bit produced by this step
);

  logic [WIDTH:0] shifted_s;
  logic           fits_s;

  // The full-width compare stands in for the sign of the trial subtraction.
  assign shifted_s = {p_i[WIDTH-1:0], q_msb_i};
  assign fits_s    = ({p_i, q_msb_i} >= {2'b00, dvs_i});

  // Keep the difference when the divisor fits, otherwise restore.
  always_comb begin
    p_o     = shifted_s;
    q_bit_o = 1'b0;
    if (fits_s) begin
      p_o     = shifted_s - {1'b0, dvs_i};
      q_bit_o = 1'b1;
    end else begin
      p_o     = shifted_s;
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/seq_div8_core.sv
// Sequential radix-2 restoring divider with independent operand signedness.
// Fixed latency of WIDTH+1 cycles from accept to the one-cycle done pulse.
module seq_div8_core
  import seq_div8_core_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       sign_mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Magnitude of the most negative representable signed value.
  localparam logic [WIDTH-1:0] MIN_MAG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   part_q, part_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] num_q, num_d;
  op_ctx_t          ctx_q, ctx_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_part_s;
  logic             step_bit_s;
  logic [WIDTH-1:0] num_abs_s;
  logic [WIDTH-1:0] dvs_abs_s;
  logic [WIDTH-1:0] quo_neg_s;
  logic [WIDTH-1:0] rem_neg_s;
  logic             q_negate_s;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .p_i     (part_q),
    .q_msb_i (quo_q[WIDTH-1]),
    .dvs_i   (dvs_q),
    .p_o     (step_part_s),
    .q_bit_o (step_bit_s)
  );

  assign num_abs_s  = WIDTH'(f_abs({{(FW-WIDTH){dividend[WIDTH-1]}}, dividend}, sign_mode[1]));
  assign dvs_abs_s  = WIDTH'(f_abs({{(FW-WIDTH){divisor[WIDTH-1]}}, divisor}, sign_mode[0]));
  assign quo_neg_s  = WIDTH'(f_neg(FW'(quo_q)));
  assign rem_neg_s  = WIDTH'(f_neg(FW'(part_q[WIDTH-1:0])));
  assign q_negate_s = ctx_q.sign_n ^ ctx_q.sign_d;

  // Next-state logic: accept, iterate, then sign fix-up and result update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    part_d      = part_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    num_d       = num_q;
    ctx_d       = ctx_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_ITER;
          cnt_d        = '0;
          part_d       = '0;
          quo_d        = num_abs_s;
          dvs_d        = dvs_abs_s;
          num_d        = dividend;
          ctx_d.sign_n = sign_mode[1] & dividend[WIDTH-1];
          ctx_d.sign_d = sign_mode[0] & divisor[WIDTH-1];
          ctx_d.dz     = (divisor == '0);
          ctx_d.uns    = (sign_mode == 2'b00);
          busy_d       = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        part_d = step_part_s;
        quo_d  = {quo_q[WIDTH-2:0], step_bit_s};
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (ctx_q.dz) begin
          quotient_d  = '1;
          remainder_d = num_q;
          dbz_d       = 1'b1;
          ovf_d       = 1'b0;
        end else begin
          quotient_d  = q_negate_s   ? quo_neg_s : quo_q;
          remainder_d = ctx_q.sign_n ? rem_neg_s : part_q[WIDTH-1:0];
          dbz_d       = 1'b0;
          if (ctx_q.uns) begin
            ovf_d = 1'b0;
          end else if (q_negate_s) begin
            ovf_d = (quo_q > MIN_MAG);
          end else begin
            ovf_d = quo_q[WIDTH-1];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      part_q      <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      num_q       <= '0;
      ctx_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      part_q      <= part_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      num_q       <= num_d;
      ctx_q       <= ctx_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div8_core.sv
// Self-checking bench for seq_div8_core (WIDTH=8): directed vector table,
// hand-written multi-cycle sequences and a randomized reference-model run.
module tb_seq_div8_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [1:0] sign_mode;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] n;
    logic [7:0] d;
    logic [1:0] m;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t vecs[14];

  seq_div8_core #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .sign_mode   (sign_mode),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands for one cycle; returns at the falling edge after accept.
  task automatic launch(input logic [7:0] n, input logic [7:0] d, input logic [1:0] m);
    @(negedge clk);
    dividend  = n;
    divisor   = d;
    sign_mode = m;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count rising edges after accept until done; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int lat, input logic [7:0] q,
                              input logic [7:0] r, input logic dz, input logic ov);
    chk({tag, ".latency"}, lat, 9);
    chk({tag, ".quotient"}, quotient, q);
    chk({tag, ".remainder"}, remainder, r);
    chk({tag, ".div_by_zero"}, div_by_zero, dz);
    chk({tag, ".overflow"}, overflow, ov);
  endtask

  // Independent reference using integer arithmetic.
  function automatic void model(input logic [7:0] n, input logic [7:0] d, input logic [1:0] m,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov);
    int nv, dv, qt, rt;
    nv = m[1] ? int'($signed(n)) : int'({24'd0, n});
    dv = m[0] ? int'($signed(d)) : int'({24'd0, d});
    if (dv == 0) begin
      q = 8'hFF; r = n; dz = 1'b1; ov = 1'b0;
    end else begin
      qt = nv / dv;
      rt = nv % dv;
      q  = qt[7:0];
      r  = rt[7:0];
      dz = 1'b0;
      ov = (m != 2'b00) && (qt > 127 || qt < -128);
    end
  endfunction

  initial begin
    int lat;
    int dcount;
    logic [7:0] eq, er, n, d;
    logic [1:0] m;
    logic edz, eov;

    vecs[0]  = '{8'd100, 8'd7,   2'b00, 8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{8'h9C,  8'd7,   2'b11, 8'hF2, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{8'd100, 8'hF9,  2'b11, 8'hF2, 8'h02, 1'b0, 1'b0};
    vecs[3]  = '{8'hC8,  8'hFD,  2'b01, 8'hBE, 8'h02, 1'b0, 1'b0};
    vecs[4]  = '{8'h80,  8'hFF,  2'b11, 8'h80, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{8'h37,  8'h00,  2'b00, 8'hFF, 8'h37, 1'b1, 1'b0};
    vecs[6]  = '{8'h37,  8'h00,  2'b11, 8'hFF, 8'h37, 1'b1, 1'b0};
    vecs[7]  = '{8'hFF,  8'h01,  2'b00, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{8'h80,  8'hFF,  2'b10, 8'h00, 8'h80, 1'b0, 1'b0};
    vecs[9]  = '{8'hFF,  8'hFF,  2'b01, 8'h01, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{8'd7,   8'd100, 2'b00, 8'h00, 8'h07, 1'b0, 1'b0};
    vecs[11] = '{8'h81,  8'h02,  2'b10, 8'hC1, 8'hFF, 1'b0, 1'b0};
    vecs[12] = '{8'h80,  8'h01,  2'b11, 8'h80, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{8'h80,  8'h00,  2'b11, 8'hFF, 8'h80, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0; sign_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outputs", {quotient, remainder, busy, done, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      launch(vecs[i].n, vecs[i].d, vecs[i].m);
      wait_done(lat);
      check_result($sformatf("vec%0d", i), lat, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
    end

    // Results hold and done is a single pulse.
    repeat (3) @(posedge clk);
    #1;
    chk("hold.done", done, 1'b0);
    chk("hold.quotient", quotient, 8'hFF);
    chk("hold.remainder", remainder, 8'h80);

    // Starts while busy are ignored.
    launch(8'd100, 8'd7, 2'b00);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) chk("ignore.busy", busy, 1'b1);
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
      start     = (k == 2 || k == 5);
      dividend  = 8'd9;
      divisor   = 8'd3;
      sign_mode = 2'b11;
    end
    start = 1'b0;
    check_result("ignore", lat, 8'h0E, 8'h02, 1'b0, 1'b0);

    // Back-to-back start in the done cycle.
    @(negedge clk);
    dividend = 8'h9C; divisor = 8'd7; sign_mode = 2'b11; start = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b.busy", busy, 1'b1);
    chk("b2b.done_single", done, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check_result("b2b", lat, 8'hF2, 8'hFE, 1'b0, 1'b0);

    // Reset during iteration 4: everything clears, the lost op never completes.
    launch(8'd100, 8'd7, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset.outputs", {quotient, remainder, busy, done, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcount++;
    end
    chk("midreset.idle", dcount, 0);
    launch(8'd100, 8'hF9, 2'b11);
    wait_done(lat);
    check_result("postreset", lat, 8'hF2, 8'h02, 1'b0, 1'b0);

    // Randomized operations in all four modes.
    for (int i = 0; i < 2000; i++) begin
      n = 8'($urandom);
      d = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      m = 2'(i % 4);
      model(n, d, m, eq, er, edz, eov);
      launch(n, d, m);
      wait_done(lat);
      check_result($sformatf("rand%0d n=%0h d=%0h m=%0d", i, n, d, m), lat, eq, er, edz, eov);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
